// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared constants for the two-port memory arbiter: FSM state
//            encoding, requester port indices, default bus widths and a
//            small one-hot helper.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Default bus widths (byte address, data word)
   localparam int ADDR_W_DEFAULT = 32;
   localparam int DATA_W_DEFAULT = 32;

   // Requester indices. A port index is one bit wide so it can be used
   // directly as the arbiter grant value.
   localparam logic PORT_IF = 1'b0;   // instruction fetch
   localparam logic PORT_LS = 1'b1;   // load/store

   // Sequencer states
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   // Convert a port index into its bit in a 2-bit per-port vector
   function automatic logic [1:0] port_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Purely combinational two-way round-robin picker. When both
//            requests are active the port that did not win last time is
//            chosen; with a single request that port is chosen.
// Ports    : req[1:0]     in   per-port request
//            last_grant   in   index of the previously granted port
//            grant        out  selected port index (meaningful if any_req)
//            any_req      out  at least one request is active
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   always_comb begin
      any_req = |req;
      unique case (req)
         2'b11:   grant = ~last_grant;   // tie: alternate
         2'b10:   grant = PORT_LS;
         2'b01:   grant = PORT_IF;
         default: grant = last_grant;    // no request: value unused
      endcase
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter and sequencer sharing one single-port
//            1024-word memory between an instruction-fetch port (0) and a
//            load/store port (1). A request is accepted in IDLE, the memory
//            is driven for exactly one ACCESS cycle, and a one-cycle
//            response pulse follows with the registered read data.
// Ports    : clk                     in   clock, rising edge
//            rst                     in   synchronous active-high reset
//            req_valid[1:0]          in   per-port request valid
//            req_ready[1:0]          out  per-port accept
//            req_we[1:0]             in   per-port write enable
//            req_addr0/1             in   byte addresses
//            req_wdata0/1            in   write data
//            resp_valid[1:0]         out  one-cycle completion pulse
//            resp_rdata              out  read data (0 after a write)
//            MemRead/MemWrite        out  memory strobes (ACCESS only)
//            address/write_data      out  memory address / write data
//            read_data               in   combinational memory read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_we,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   // ------------------------------------------------------------------------
   // State and latched request
   // ------------------------------------------------------------------------
   logic [0:0]        state;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_grant;
   logic              last_grant;

   // Arbiter result and derived control
   logic              grant;
   logic              any_req;
   logic              in_idle;
   logic              in_access;
   logic              handshake;

   // Selected requester payload
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .any_req    (any_req)
   );

   assign in_idle   = (state == ST_IDLE);
   assign in_access = (state == ST_ACCESS);

   // The picker only ever grants a port whose valid is set, so driving the
   // granted bit whenever any request is present is the same as
   // ready[grant] = valid[grant]. Reset blocks any handshake.
   always_comb begin
      req_ready = 2'b00;
      if (in_idle && !rst && any_req) begin
         req_ready = port_onehot(grant);
      end
   end

   assign handshake = |(req_valid & req_ready);

   always_comb begin
      sel_we    = req_we[grant];
      sel_addr  = (grant == PORT_LS) ? req_addr1  : req_addr0;
      sel_wdata = (grant == PORT_LS) ? req_wdata1 : req_wdata0;
   end

   // ------------------------------------------------------------------------
   // Memory side. The strobes are gated by rst combinationally so that a
   // reset landing in the ACCESS cycle cannot commit a write on that edge.
   // Address and write data always reflect the latched registers.
   // ------------------------------------------------------------------------
   assign MemRead    = in_access & ~lat_we & ~rst;
   assign MemWrite   = in_access &  lat_we & ~rst;
   assign address    = lat_addr;
   assign write_data = lat_wdata;

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_grant  <= PORT_IF;
         last_grant <= PORT_LS;   // makes port 0 win the first tie
         resp_valid <= 2'b00;
         resp_rdata <= '0;
      end else begin
         // Response is a single-cycle pulse; resp_rdata holds its value.
         resp_valid <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  lat_we     <= sel_we;
                  lat_addr   <= sel_addr;
                  lat_wdata  <= sel_wdata;
                  lat_grant  <= grant;
                  last_grant <= grant;
                  state      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               resp_rdata <= lat_we ? '0 : read_data;
               resp_valid <= port_onehot(lat_grant);
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: a table of single
//            transactions, hand-written multi-cycle sequences (tie
//            alternation, streaming, reset mid-write, ready-hold) and a
//            randomized phase checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [1:0]    req_we;
   logic [AW-1:0] req_addr0, req_addr1;
   logic [DW-1:0] req_wdata0, req_wdata1;
   logic [1:0]    resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          MemRead, MemWrite;
   logic [AW-1:0] address;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;

   // Bench memory and its expected-contents copy
   logic [31:0] mem     [1024];
   logic [31:0] ref_mem [1024];
   logic        pre_en = 1'b0;
   logic [9:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data)
   );

   assign read_data = MemRead ? mem[address[11:2]] : '0;

   always @(posedge clk) begin
      if (pre_en)        mem[pre_idx]       <= pre_data;
      else if (MemWrite) mem[address[11:2]] <= write_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      pre_en   = 1'b1;
      pre_idx  = idx[9:0];
      pre_data = d;
      ref_mem[idx] = d;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic idle_inputs();
      req_valid  = 2'b00;
      req_we     = 2'b00;
      req_addr0  = '0;
      req_addr1  = '0;
      req_wdata0 = '0;
      req_wdata1 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct packed {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   // One isolated transaction starting from an IDLE negedge
   task automatic do_txn(input vec_t v);
      logic [1:0] oh;
      oh = v.port ? 2'b10 : 2'b01;
      req_valid = oh;
      req_we    = v.we ? oh : 2'b00;
      if (v.port) begin req_addr1 = v.addr; req_wdata1 = v.wdata; end
      else        begin req_addr0 = v.addr; req_wdata0 = v.wdata; end
      #1;
      check("txn_ready", {30'd0, req_ready}, {30'd0, oh});
      @(negedge clk);
      req_valid = 2'b00;
      check("txn_MemRead",  {31'd0, MemRead},  {31'd0, ~v.we});
      check("txn_MemWrite", {31'd0, MemWrite}, {31'd0, v.we});
      check("txn_address",  address, v.addr);
      if (v.we) check("txn_write_data", write_data, v.wdata);
      check("txn_resp_idle", {30'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check("txn_resp_valid", {30'd0, resp_valid}, {30'd0, oh});
      check("txn_resp_rdata", resp_rdata, v.exp_rdata);
   endtask

   // Randomized traffic checked against a transaction-level model:
   // a request is accepted in the first free cycle, ties alternate,
   // and each access produces a response two edges after acceptance.
   task automatic random_phase(input int ncyc);
      logic [1:0]  pend;
      logic        pwe [2];
      logic [31:0] pad [2];
      logic [31:0] pwd [2];
      logic        m_last;
      bit          acc_v, acc_next, rsp_v;
      logic        acc_p, acc_we, rsp_p, g;
      logic [31:0] acc_a, acc_d, rsp_d, hold_d;
      pend = 2'b00; m_last = 1'b1; acc_v = 0; rsp_v = 0;
      acc_p = 0; acc_we = 0; rsp_p = 0; acc_a = 0; acc_d = 0; rsp_d = 0; hold_d = 0;
      for (int i = 0; i < 2; i++) begin pwe[i] = 0; pad[i] = 0; pwd[i] = 0; end
      for (int c = 0; c < ncyc; c++) begin
         check("rnd_resp_valid", {30'd0, resp_valid}, rsp_v ? (rsp_p ? 32'd2 : 32'd1) : 32'd0);
         if (rsp_v) hold_d = rsp_d;
         check("rnd_resp_rdata", resp_rdata, hold_d);
         check("rnd_MemRead",  {31'd0, MemRead},  {31'd0, acc_v && !acc_we});
         check("rnd_MemWrite", {31'd0, MemWrite}, {31'd0, acc_v && acc_we});
         if (acc_v) begin
            check("rnd_address", address, acc_a);
            if (acc_we) check("rnd_write_data", write_data, acc_d);
         end
         rsp_v = acc_v;
         rsp_p = acc_p;
         if (acc_v) begin
            if (acc_we) begin ref_mem[acc_a[11:2]] = acc_d; rsp_d = 32'd0; end
            else rsp_d = ref_mem[acc_a[11:2]];
         end
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom % 3) != 0) begin
               pend[i] = 1'b1;
               pwe[i]  = 1'($urandom % 2);
               pad[i]  = 32'(($urandom % 16) * 4 + ($urandom % 4));
               pwd[i]  = $urandom;
            end
         end
         req_valid  = pend;
         req_we     = {pwe[1], pwe[0]};
         req_addr0  = pad[0];  req_addr1  = pad[1];
         req_wdata0 = pwd[0];  req_wdata1 = pwd[1];
         #1;
         acc_next = 0;
         if (!acc_v && pend != 2'b00) begin
            g = (pend == 2'b11) ? ~m_last : pend[1];
            check("rnd_ready", {30'd0, req_ready}, g ? 32'd2 : 32'd1);
            acc_next = 1; acc_p = g; acc_we = pwe[g]; acc_a = pad[g]; acc_d = pwd[g];
            pend[g] = 1'b0;
            m_last  = g;
         end else begin
            check("rnd_ready", {30'd0, req_ready}, 32'd0);
         end
         acc_v = acc_next;
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_t [2];
      logic [31:0] s_addr [4];
      logic [31:0] s_data [4];
      idle_inputs();
      @(negedge clk);
      preload(4,  32'hDEADBEEF);
      preload(16, 32'h0BADF00D);

      // ---- reset state (valid asserted while in reset) ----
      req_valid = 2'b11;
      #1;
      check("rst_ready",      {30'd0, req_ready},  32'd0);
      check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_MemRead",    {31'd0, MemRead},  32'd0);
      check("rst_MemWrite",   {31'd0, MemWrite}, 32'd0);
      check("rst_address",    address,    32'd0);
      check("rst_write_data", write_data, 32'd0);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;

      // ---- table of isolated transactions ----
      vecs[0] = '{port:1'b0, we:1'b0, addr:32'h10, wdata:32'h0,        exp_rdata:32'hDEADBEEF};
      vecs[1] = '{port:1'b1, we:1'b1, addr:32'h20, wdata:32'hCAFEF00D, exp_rdata:32'h0};
      vecs[2] = '{port:1'b1, we:1'b0, addr:32'h20, wdata:32'h0,        exp_rdata:32'hCAFEF00D};
      vecs[3] = '{port:1'b0, we:1'b1, addr:32'h24, wdata:32'h11112222, exp_rdata:32'h0};
      vecs[4] = '{port:1'b1, we:1'b0, addr:32'h24, wdata:32'h0,        exp_rdata:32'h11112222};
      vecs[5] = '{port:1'b0, we:1'b0, addr:32'h13, wdata:32'h0,        exp_rdata:32'hDEADBEEF};
      for (int i = 0; i < 6; i++) do_txn(vecs[i]);

      // ---- tie from reset: grants 0,1,0,1, one accept every 2 cycles ----
      do_reset();
      exp_t[0] = 32'hDEADBEEF;  exp_t[1] = 32'hCAFEF00D;
      req_valid = 2'b11; req_we = 2'b00; req_addr0 = 32'h10; req_addr1 = 32'h20;
      for (int k = 0; k < 10; k++) begin
         if (k >= 2 && (k % 2) == 0) begin
            check("tie_resp_valid", {30'd0, resp_valid}, (((k - 2) % 4) == 0) ? 32'd1 : 32'd2);
            check("tie_resp_rdata", resp_rdata, exp_t[((k - 2) % 4) / 2]);
         end else begin
            check("tie_resp_idle", {30'd0, resp_valid}, 32'd0);
         end
         #1;
         check("tie_ready", {30'd0, req_ready},
               ((k % 4) == 0) ? 32'd1 : (((k % 4) == 2) ? 32'd2 : 32'd0));
         @(negedge clk);
      end

      // ---- port 1 streaming 4 reads ----
      do_reset();
      s_addr[0] = 32'h10; s_addr[1] = 32'h20; s_addr[2] = 32'h24; s_addr[3] = 32'h13;
      s_data[0] = 32'hDEADBEEF; s_data[1] = 32'hCAFEF00D;
      s_data[2] = 32'h11112222; s_data[3] = 32'hDEADBEEF;
      for (int k = 0; k < 10; k++) begin
         if (k >= 2 && (k % 2) == 0) begin
            check("stream_resp_valid", {30'd0, resp_valid}, 32'd2);
            check("stream_resp_rdata", resp_rdata, s_data[k / 2 - 1]);
         end else begin
            check("stream_resp_idle", {30'd0, resp_valid}, 32'd0);
         end
         if (k < 8) begin
            if ((k % 2) == 0) req_addr1 = s_addr[k / 2];
            req_valid = 2'b10;
         end else begin
            req_valid = 2'b00;
         end
         #1;
         check("stream_ready", {30'd0, req_ready}, (k < 8 && (k % 2) == 0) ? 32'd2 : 32'd0);
         @(negedge clk);
      end

      // ---- reset in the ACCESS cycle of a write ----
      do_reset();
      req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'h40; req_wdata0 = 32'h12345678;
      #1;
      check("rmw_ready", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      check("rmw_MemWrite_pre", {31'd0, MemWrite}, 32'd1);
      rst = 1'b1;
      #1;
      check("rmw_MemWrite_gated", {31'd0, MemWrite}, 32'd0);
      check("rmw_MemRead_gated",  {31'd0, MemRead},  32'd0);
      @(negedge clk);
      check("rmw_resp_valid", {30'd0, resp_valid}, 32'd0);
      check("rmw_resp_rdata", resp_rdata, 32'd0);
      check("rmw_address",    address,    32'd0);
      check("rmw_write_data", write_data, 32'd0);
      check("rmw_mem_kept",   mem[16],    32'h0BADF00D);
      req_valid = 2'b01; req_we = 2'b00;   // valid during reset: no handshake
      #1;
      check("rmw_idle_rst_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("rmw_no_access", {31'd0, MemRead}, 32'd0);
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      check("rmw_no_resp", {30'd0, resp_valid}, 32'd0);
      do_txn('{port:1'b0, we:1'b0, addr:32'h40, wdata:32'h0, exp_rdata:32'h0BADF00D});

      // ---- ready-hold: port 0 waits while port 1 is in flight ----
      do_reset();
      req_valid = 2'b10; req_we = 2'b00; req_addr1 = 32'h20;
      #1;
      check("hold_ready_p1", {30'd0, req_ready}, 32'd2);
      @(negedge clk);
      req_valid = 2'b01; req_addr0 = 32'h24;
      #1;
      check("hold_ready_busy", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("hold_resp1_valid", {30'd0, resp_valid}, 32'd2);
      check("hold_resp1_rdata", resp_rdata, 32'hCAFEF00D);
      #1;
      check("hold_ready_p0", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      check("hold_access_addr", address, 32'h24);
      check("hold_access_rd",   {31'd0, MemRead}, 32'd1);
      check("hold_resp_idle",   {30'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check("hold_resp0_valid", {30'd0, resp_valid}, 32'd1);
      check("hold_resp0_rdata", resp_rdata, 32'h11112222);
      @(negedge clk);
      check("hold_no_dup", {30'd0, resp_valid}, 32'd0);

      // ---- randomized traffic ----
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      rst = 1'b0;
      random_phase(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
